// File: rtl/fcs_check.sv
// fcs_check: receive-side frame checker for one 8-bit RX lane.
// Strips preamble/SFD and forwards DA..FCS with sof/eof markers at a fixed
// two-cycle latency. On the last byte it reports CRC-32 residue and length
// errors, and it keeps saturating good/bad frame counters.
module fcs_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_ctrl,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_fcs_err,
  output logic             out_len_err,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    FRAME,
    DROP
  } state_t;

  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [2:0]  PRE_LIMIT   = 3'd7;

  // Byte counter is 11 bits and sticks at all ones, which is well past MAX_LEN.
  localparam int               LEN_W     = 11;
  localparam logic [LEN_W-1:0] LEN_SAT   = '1;
  localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  // Reflected CRC-32 update for one byte, data bits taken LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc,
                                           input logic [7:0]  data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         pre_cnt_q, pre_cnt_d;
  logic [31:0]        crc_q, crc_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         s1_data_q, s1_data_d;
  logic               s1_full_q, s1_full_d;
  logic               s1_sof_q, s1_sof_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_sof_q, out_sof_d;
  logic               out_eof_q, out_eof_d;
  logic               out_fcs_err_q, out_fcs_err_d;
  logic               out_len_err_q, out_len_err_d;
  logic [CNT_W-1:0]   good_q, good_d;
  logic [CNT_W-1:0]   bad_q, bad_d;

  logic               fcs_bad;
  logic               len_bad;

  // Next-state, hold-register, CRC/length tracking and output selection.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the value.
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    crc_d         = crc_q;
    len_d         = len_q;
    s1_data_d     = s1_data_q;
    s1_full_d     = s1_full_q;
    s1_sof_d      = s1_sof_q;
    out_data_d    = 8'h00;
    out_valid_d   = 1'b0;
    out_sof_d     = 1'b0;
    out_eof_d     = 1'b0;
    out_fcs_err_d = 1'b0;
    out_len_err_d = 1'b0;
    good_d        = good_q;
    bad_d         = bad_q;

    // The CRC and count already include the byte sitting in s1.
    fcs_bad = (crc_q != CRC_RESIDUE);
    len_bad = (len_q < MIN_LEN_L) || (len_q > MAX_LEN_L);

    unique case (state_q)
      IDLE: begin
        if (rx_ctrl) begin
          if (rx_data == PRE_BYTE) begin
            state_d   = PREAMBLE;
            pre_cnt_d = 3'd1;
          end else begin
            state_d = DROP;
          end
        end
      end

      PREAMBLE: begin
        if (!rx_ctrl) begin
          state_d = IDLE;
        end else if (rx_data == SFD_BYTE) begin
          state_d   = FRAME;
          crc_d     = CRC_INIT;
          len_d     = '0;
          s1_full_d = 1'b0;
          s1_sof_d  = 1'b0;
        end else if (rx_data == PRE_BYTE && pre_cnt_q != PRE_LIMIT) begin
          pre_cnt_d = pre_cnt_q + 3'd1;
        end else begin
          state_d = DROP;
        end
      end

      FRAME: begin
        if (rx_ctrl) begin
          // A new byte pushes the held one out, keeping latency fixed.
          if (s1_full_q) begin
            out_valid_d = 1'b1;
            out_data_d  = s1_data_q;
            out_sof_d   = s1_sof_q;
          end
          s1_data_d = rx_data;
          s1_full_d = 1'b1;
          s1_sof_d  = !s1_full_q;
          crc_d     = crc_byte(crc_q, rx_data);
          len_d     = (len_q == LEN_SAT) ? len_q : len_q + LEN_W'(1);
        end else begin
          // rx_ctrl fell: the held byte is the last FCS byte.
          state_d   = IDLE;
          s1_full_d = 1'b0;
          s1_sof_d  = 1'b0;
          if (s1_full_q) begin
            out_valid_d   = 1'b1;
            out_data_d    = s1_data_q;
            out_sof_d     = s1_sof_q;
            out_eof_d     = 1'b1;
            out_fcs_err_d = fcs_bad;
            out_len_err_d = len_bad;
            if (fcs_bad || len_bad) begin
              if (bad_q != '1) bad_d = bad_q + CNT_W'(1);
            end else begin
              if (good_q != '1) good_d = good_q + CNT_W'(1);
            end
          end
        end
      end

      DROP: begin
        if (!rx_ctrl) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers; reset clears outputs so an aborted frame
  // never produces an eof.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q       <= IDLE;
      pre_cnt_q     <= 3'd0;
      crc_q         <= CRC_INIT;
      len_q         <= '0;
      s1_data_q     <= 8'h00;
      s1_full_q     <= 1'b0;
      s1_sof_q      <= 1'b0;
      out_data_q    <= 8'h00;
      out_valid_q   <= 1'b0;
      out_sof_q     <= 1'b0;
      out_eof_q     <= 1'b0;
      out_fcs_err_q <= 1'b0;
      out_len_err_q <= 1'b0;
      good_q        <= '0;
      bad_q         <= '0;
    end else begin
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      crc_q         <= crc_d;
      len_q         <= len_d;
      s1_data_q     <= s1_data_d;
      s1_full_q     <= s1_full_d;
      s1_sof_q      <= s1_sof_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_sof_q     <= out_sof_d;
      out_eof_q     <= out_eof_d;
      out_fcs_err_q <= out_fcs_err_d;
      out_len_err_q <= out_len_err_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_sof     = out_sof_q;
  assign out_eof     = out_eof_q;
  assign out_fcs_err = out_fcs_err_q;
  assign out_len_err = out_len_err_q;
  assign good_cnt    = good_q;
  assign bad_cnt     = bad_q;

endmodule

// File: tb/tb_fcs_check.sv
// tb_fcs_check: directed vector table, hand-written back-to-back and
// reset-abort sequences, and randomized frames checked against a
// table-driven CRC-32 reference model.
module tb_fcs_check;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int CNT_W   = 4;   // small so counter saturation is reachable

  typedef logic [7:0] bytes_t[$];

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       fcs;
    logic       len;
    int         cyc;
  } obs_t;

  typedef struct {
    string name;
    int    len;
    int    npre;
    bit    sfd;
    bit    with_fcs;
    int    corrupt;
    bit    exp_out;
    bit    exp_fcs;
    bit    exp_len;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       rx_data;
  logic             rx_ctrl;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_sof;
  logic             out_eof;
  logic             out_fcs_err;
  logic             out_len_err;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] bad_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int idle_bad = 0;
  int exp_good = 0;
  int exp_bad = 0;

  obs_t got_q[$];
  obs_t exp_q[$];
  logic [31:0] crc_tbl [256];

  fcs_check #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_ctrl    (rx_ctrl),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_fcs_err(out_fcs_err),
    .out_len_err(out_len_err),
    .good_cnt   (good_cnt),
    .bad_cnt    (bad_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Collect output bytes on the falling edge; note any flag raised without valid.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid)
        got_q.push_back('{out_data, out_sof, out_eof, out_fcs_err, out_len_err, cyc});
      else if (out_sof || out_eof || out_fcs_err || out_len_err)
        idle_bad = idle_bad + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_raw(input bytes_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) c = (c >> 8) ^ crc_tbl[c[7:0] ^ b[i]];
    return c;
  endfunction

  function automatic bytes_t make_frame(input int len, input bit rnd,
                                        input bit with_fcs, input int corrupt);
    bytes_t f;
    logic [31:0] fcs;
    int dlen;
    f = {};
    dlen = (with_fcs && len >= 4) ? len - 4 : len;
    for (int i = 0; i < dlen; i++) f.push_back(rnd ? 8'($urandom) : 8'h00);
    if (with_fcs && len >= 4) begin
      fcs = ~crc_raw(f);
      for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
    end
    if (corrupt >= 0) f[corrupt] = f[corrupt] ^ 8'h01;
    return f;
  endfunction

  task automatic drive(input logic [7:0] b, input logic c);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_ctrl = c;
  endtask

  task automatic send(input bytes_t f, input int npre, input bit sfd,
                      input int gap, output int first_cyc);
    first_cyc = -1;
    repeat (npre) drive(8'h55, 1'b1);
    if (sfd) drive(8'hD5, 1'b1);
    foreach (f[i]) begin
      drive(f[i], 1'b1);
      if (i == 0) first_cyc = cyc;
    end
    repeat (gap) drive(8'h00, 1'b0);
  endtask

  function automatic int sat_inc(input int v);
    return (v == (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  // Scoreboard entry for one forwarded frame; sof is due two cycles after
  // the first frame byte is presented.
  task automatic expect_frame(input bytes_t f, input bit fcs, input bit len, input int first_cyc);
    foreach (f[i]) begin
      exp_q.push_back('{f[i], (i == 0), (i == f.size() - 1),
                        (i == f.size() - 1) ? fcs : 1'b0,
                        (i == f.size() - 1) ? len : 1'b0,
                        (i == 0) ? first_cyc + 2 : -1});
    end
    if (fcs || len) exp_bad = sat_inc(exp_bad);
    else            exp_good = sat_inc(exp_good);
  endtask

  task automatic compare_stream(input string name);
    int n;
    check({name, "_nbytes"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({name, "_byte"},
            {got_q[i].sof, got_q[i].eof, got_q[i].fcs, got_q[i].len, got_q[i].data},
            {exp_q[i].sof, exp_q[i].eof, exp_q[i].fcs, exp_q[i].len, exp_q[i].data});
      if (exp_q[i].sof) check({name, "_sof_latency"}, got_q[i].cyc, exp_q[i].cyc);
      if (got_q[i].data !== exp_q[i].data) break;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_counters(input string name);
    check({name, "_good_cnt"}, good_cnt, exp_good);
    check({name, "_bad_cnt"}, bad_cnt, exp_bad);
    check({name, "_idle_flags"}, idle_bad, 0);
  endtask

  initial begin
    vec_t   vecs[$];
    bytes_t f;
    bytes_t f2;
    int     c1;
    int     c2;
    int     eofs;

    for (int n = 0; n < 256; n++) begin
      logic [31:0] v;
      v = 32'(n);
      repeat (8) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
      crc_tbl[n] = v;
    end

    //          name          len  npre sfd fcs corrupt out fcs_e len_e
    vecs.push_back('{"good64",      64,  7, 1, 1, -1, 1, 0, 0});
    vecs.push_back('{"corrupt10",   64,  7, 1, 1, 10, 1, 1, 0});
    vecs.push_back('{"runt40",      40,  7, 1, 1, -1, 1, 0, 1});
    vecs.push_back('{"long1519",  1519,  7, 1, 1, -1, 1, 0, 1});
    vecs.push_back('{"max1518",   1518,  7, 1, 1, -1, 1, 0, 0});
    vecs.push_back('{"len63",       63,  7, 1, 1, -1, 1, 0, 1});
    vecs.push_back('{"one_byte",     1,  7, 1, 0, -1, 1, 1, 1});
    vecs.push_back('{"empty",        0,  7, 1, 0, -1, 0, 0, 0});
    vecs.push_back('{"no_sfd",      16,  8, 0, 0, -1, 0, 0, 0});
    vecs.push_back('{"after_nosfd", 64,  7, 1, 1, -1, 1, 0, 0});
    vecs.push_back('{"bad_pre",     10,  3, 0, 0, -1, 0, 0, 0});
    vecs.push_back('{"no_pre",      64,  0, 1, 1, -1, 0, 0, 0});
    vecs.push_back('{"short_pre",   64,  1, 1, 1, -1, 1, 0, 0});

    reset   = 1'b1;
    rx_data = 8'h00;
    rx_ctrl = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          {out_valid, out_sof, out_eof, out_fcs_err, out_len_err, out_data, good_cnt, bad_cnt},
          '0);
    reset = 1'b0;
    repeat (2) drive(8'h00, 1'b0);

    // Directed vector table.
    foreach (vecs[v]) begin
      f = make_frame(vecs[v].len, 1'b0, vecs[v].with_fcs, vecs[v].corrupt);
      send(f, vecs[v].npre, vecs[v].sfd, 3, c1);
      repeat (2) drive(8'h00, 1'b0);
      if (vecs[v].exp_out) expect_frame(f, vecs[v].exp_fcs, vecs[v].exp_len, c1);
      compare_stream(vecs[v].name);
      check_counters(vecs[v].name);
    end

    // Back-to-back frames with a single idle cycle between them.
    f  = make_frame(64, 1'b1, 1'b1, -1);
    f2 = make_frame(64, 1'b1, 1'b1, -1);
    send(f, 7, 1'b1, 1, c1);
    send(f2, 7, 1'b1, 3, c2);
    repeat (2) drive(8'h00, 1'b0);
    expect_frame(f, 1'b0, 1'b0, c1);
    expect_frame(f2, 1'b0, 1'b0, c2);
    compare_stream("back2back");
    check_counters("back2back");

    // Reset asserted for one cycle at byte 30 of a frame.
    f = make_frame(64, 1'b1, 1'b1, -1);
    repeat (7) drive(8'h55, 1'b1);
    drive(8'hD5, 1'b1);
    for (int i = 0; i < 30; i++) drive(f[i], 1'b1);
    #2;
    reset   = 1'b1;
    rx_ctrl = 1'b0;
    #1;
    check("reset_mid_outs",
          {out_valid, out_sof, out_eof, out_fcs_err, out_len_err, good_cnt, bad_cnt}, '0);
    eofs = 0;
    foreach (got_q[i]) if (got_q[i].eof) eofs++;
    check("abort_no_eof", eofs, 0);
    got_q.delete();
    exp_good = 0;
    exp_bad  = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) drive(8'h00, 1'b0);
    f = make_frame(64, 1'b1, 1'b1, -1);
    send(f, 7, 1'b1, 3, c1);
    repeat (2) drive(8'h00, 1'b0);
    expect_frame(f, 1'b0, 1'b0, c1);
    compare_stream("after_reset");
    check_counters("after_reset");

    // Randomized frames against the reference model; counters saturate here.
    for (int k = 0; k < 40; k++) begin
      int  len;
      int  corrupt;
      bit  with_fcs;
      bit  m_fcs;
      bit  m_len;
      len = $urandom_range(1, 130);
      if ($urandom_range(0, 9) == 0) len = $urandom_range(60, 70);
      with_fcs = ($urandom_range(0, 3) != 0);
      corrupt  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      f = make_frame(len, 1'b1, with_fcs, corrupt);
      send(f, $urandom_range(1, 7), 1'b1, $urandom_range(1, 3), c1);
      m_fcs = (crc_raw(f) != 32'hDEBB20E3);
      m_len = (len < MIN_LEN) || (len > MAX_LEN);
      expect_frame(f, m_fcs, m_len, c1);
    end
    repeat (4) drive(8'h00, 1'b0);
    compare_stream("random");
    check_counters("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fcs_check.md
Name: fcs_check

Overview:
- Per-port receive-side stage that sits between one 8-bit RX lane (RXDn/RXCn) and that port's input buffer. switchcore instantiates four of them.
- Strips preamble/SFD and forwards the frame bytes (DA through FCS) with start and end markers.
- Computes CRC-32 over each frame and checks its length.
- Flags the frame's good/bad status on its last byte so the downstream FIFO can commit or discard it.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes (DA..FCS inclusive)
- MAX_LEN, 1518, maximum legal frame length in bytes
- CNT_W, 16, width of the saturating good/bad frame counters

Ports:
- clk  in  1  core clock, one byte per cycle
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  receive byte
- rx_ctrl  in  1  receive data valid (high during preamble+frame)
- out_data  out  8  frame byte
- out_valid  out  1  out_data is a frame byte
- out_sof  out  1  first byte of frame (DA[0]); qualified by out_valid
- out_eof  out  1  last byte of frame (FCS[3]); qualified by out_valid
- out_fcs_err  out  1  CRC residue mismatch; valid only with out_eof
- out_len_err  out  1  length < MIN_LEN or > MAX_LEN; valid only with out_eof
- good_cnt  out  CNT_W  frames with no error, saturating
- bad_cnt  out  CNT_W  frames with any error, saturating

Behaviour:
- Reset (async, active-high): all outputs 0; FSM = IDLE; CRC = 32'hFFFFFFFF; hold register empty; counters 0.
- FSM states: IDLE, PREAMBLE, FRAME, DROP.
- IDLE: rx_ctrl=1 and rx_data=8'h55 -> PREAMBLE. rx_ctrl=1 with any other byte -> DROP.
- PREAMBLE:
  - rx_data=8'hD5 -> FRAME; CRC preset to FFFFFFFF; byte count cleared.
  - 8'h55 stays in PREAMBLE, at most 7 consecutive 55s.
  - 8th non-SFD byte, or any other value -> DROP.
  - rx_ctrl=0 -> IDLE. Nothing is output.
- FRAME: each rx_ctrl=1 byte is captured into the hold register (s1). The CRC register is updated with that byte in the same edge.
  - Byte count increments, saturating at 2^11-1.
  - CRC: reflected polynomial 32'hEDB88320, LSB-first, init all ones, no final XOR.
- Output pipeline, fixed latency 2:
  - A byte sampled at edge t appears on out_data at edge t+1 (is in s1), then on the outputs at t+2.
  - While in FRAME, s1 is moved to the outputs when the next valid byte arrives or when rx_ctrl falls.
  - On the first frame byte, out_sof=1.
  - When rx_ctrl is sampled 0 with s1 full: out_eof=1 with that byte, and FSM -> IDLE.
  - out_fcs_err = (CRC register != 32'hDEBB20E3), evaluated on the register that includes the final byte.
  - out_len_err = (count < MIN_LEN) | (count > MAX_LEN).
  - out_valid=0 in all other cycles; all flags are 0 when out_valid=0.
- Frames shorter than 1 byte after SFD (rx_ctrl falls immediately): no output, no counter change.
- Single-byte frame: out_sof and out_eof both 1 in the same cycle; out_len_err=1.
- DROP: waits for rx_ctrl=0 -> IDLE. No output, no counter change.
- Counters:
  - On each out_eof, good_cnt increments if neither error flag is set; otherwise bad_cnt increments.
  - Both saturate at all ones.
- Back-to-back frames: a single rx_ctrl=0 cycle between frames is legal.
  - The eof of frame N and the preamble start of frame N+1 may overlap in the pipeline; both must be handled.
- Reset mid-frame: outputs drop to 0 immediately and no eof is emitted. The next frame starts from IDLE.

Test Plan:
- Good frame: 7x55, D5, 60 bytes 00, correct FCS (bench CRC model), rx_ctrl low -> 64 out_valid cycles. sof on first, eof on 64th, at 2-cycle latency; fcs_err=0, len_err=0; good_cnt=1.
- Corrupted frame: same frame with byte 10 XOR 8'h01 -> eof with out_fcs_err=1; bad_cnt=1, good_cnt unchanged.
- Runt: 40-byte frame with valid FCS -> out_len_err=1, out_fcs_err=0, bad_cnt+1. Repeat with 1519 bytes -> out_len_err=1.
- No SFD: rx_ctrl high for 8x55 then 16 bytes -> zero out_valid cycles, counters unchanged. Next good frame is accepted normally.
- Back-to-back: two good 64-byte frames separated by one idle cycle -> two sof/eof pairs, no merged or lost bytes, good_cnt=2.
- Reset mid-frame: assert reset at byte 30 for 1 cycle, then send a good frame -> no eof for the aborted frame, one clean frame out, good_cnt=1.
